// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//
// Contents:
//   uart_tx_state_e   - transmit FSM state encoding
//   UART_DATA_BITS    - payload bits per frame
//   UART_IDLE_LEVEL   - line level while idle and during the stop bit
//   UART_START_LEVEL  - line level of the start bit
//   UART_FRAME_BITS   - bit-times per frame (start + data [+ parity] + stop)
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit (8E1).
package uart_pkg;

    localparam int   UART_DATA_BITS   = 8;
    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

`ifdef UART_TX_PARITY_EN
    localparam int UART_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_e;
`else
    localparam int UART_FRAME_BITS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_tx_state_e;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous single-clock FIFO used as the transmit byte queue.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset; empties the queue
//   push_i   - write wdata_i (ignored while full)
//   wdata_i  - data to enqueue
//   pop_i    - drop the head entry (ignored while empty)
//   rdata_o  - current head entry (valid while not empty)
//   count_o  - number of stored entries, 0..DEPTH
//   empty_o  - no entries stored
//   full_o   - DEPTH entries stored
//
// DEPTH must be a power of two so the pointers wrap without extra logic.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;  // idle, or push+pop cancel out
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of process order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the pointers and count define which
    // entries are meaningful, so clearing them is enough to flush the queue.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// Buffered UART transmitter: byte queue plus 8N1 serialiser.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous active-high reset; aborts any frame, flushes queue
//   in_valid    - in_data is valid; accepted on an edge where in_ready is high
//   in_data     - byte to transmit
//   in_ready    - queue has room (from the registered count only)
//   uart_tx     - serial line, idles high, driven straight from a register
//   busy        - a frame is in flight or bytes are queued
//   fifo_count  - bytes queued, not counting the one being shifted out
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1, 11 bit-times per frame).
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic [UART_DATA_BITS-1:0]    in_data,
    output logic                         in_ready,
    output logic                         uart_tx,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

    uart_tx_state_e              state_q, state_d;
    logic [BAUD_W-1:0]           baud_q, baud_d;
    logic [BIT_W-1:0]            bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic                        tx_q, tx_d;

    logic                        push, pop;
    logic [UART_DATA_BITS-1:0]   fifo_head;
    logic                        fifo_empty, fifo_full;
    logic                        bit_done;

    assign in_ready = !fifo_full;
    assign push     = in_valid && !fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (in_data),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bit_done = (baud_q == BAUD_LAST);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;

        // Baud counter runs in every non-idle state and reloads on each bit boundary.
        if (state_q != ST_IDLE) begin
            baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    state_d = ST_START;
                    tx_d    = UART_START_LEVEL;
                    baud_d  = '0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = ST_STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + BIT_W'(1);
                        tx_d      = shift_q[bit_idx_q + BIT_W'(1)];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = UART_IDLE_LEVEL;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    // Chain straight into the next start bit when more bytes wait.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        state_d = ST_START;
                        tx_d    = UART_START_LEVEL;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = UART_IDLE_LEVEL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= UART_IDLE_LEVEL;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl.
// A frame-level reference model (byte queue + elapsed-cycle counter per frame)
// predicts every output each cycle; a line decoder recovers transmitted bytes
// and compares them against the bytes the model says completed.
module tb_uart_tx_ctrl;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
    int exp_a5 [NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    localparam int NB = 10;
    int exp_a5 [NB] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
    localparam int FRAME_CYC = NB * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready, uart_tx, busy;
    logic [3:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];
    logic [7:0] m_done[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_active = 1'b0;
    int         m_elapsed = 0;
    bit         m_in_reset = 1'b1;

    function automatic logic frame_level(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n <= 8) return b[n-1];
`ifdef UART_TX_PARITY_EN
        if (n == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        int sz;
        bit acc;
        m_in_reset = rst;
        if (rst) begin
            m_q.delete();
            m_active  = 1'b0;
            m_elapsed = 0;
        end else begin
            sz  = m_q.size();
            acc = in_valid && (sz != DEPTH);
            if (m_active) begin
                m_elapsed++;
                if (m_elapsed == FRAME_CYC) begin
                    m_done.push_back(m_cur);
                    m_active = 1'b0;
                end
            end
            if (!m_active && sz != 0) begin
                m_cur     = m_q.pop_front();
                m_active  = 1'b1;
                m_elapsed = 0;
            end
            if (acc) m_q.push_back(in_data);
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", 32'(uart_tx), 32'(m_active ? frame_level(m_cur, m_elapsed / CPB) : 1'b1));
            check("ready", 32'(in_ready), 32'(m_q.size() != DEPTH));
            check("busy", 32'(busy), 32'(m_active || m_q.size() != 0));
            check("count", 32'(fifo_count), 32'(m_q.size()));
        end
    end

    // ---------------- line decoder ----------------
    logic [7:0] rx_log[$];
    logic       rx_par_log[$];
    bit         rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_par = 1'b0;

    always @(negedge clk) begin
        int bit_no;
        if (m_in_reset) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (uart_tx === 1'b0) begin
                rx_on  = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
        end
        if (rx_on && (rx_cnt % CPB) == CPB / 2) begin
            bit_no = rx_cnt / CPB;
            if (bit_no >= 1 && bit_no <= 8) rx_byte[bit_no-1] = uart_tx;
            if (bit_no == 9) rx_par = uart_tx;
            if (bit_no == NB - 1) begin
                rx_log.push_back(rx_byte);
                rx_par_log.push_back(rx_par);
                rx_on = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_active || m_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", 32'(busy), 32'(0));
        repeat (2) @(negedge clk);
    endtask

    int dens [3] = '{15, 50, 95};

    initial begin
        int base;
        int ee_seen;
        int n;

        // Reset held for three edges, then 100 idle cycles.
        @(posedge clk);
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("idle_tx", 32'(uart_tx), 32'(1));
        check("idle_ready", 32'(in_ready), 32'(1));
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_count", 32'(fifo_count), 32'(0));

        // Single byte 0xA5: latency, mid-bit samples, frame length via busy.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        check("a5_before_start", 32'(uart_tx), 32'(1));
        @(negedge clk);
        check("a5_latency", 32'(uart_tx), 32'(0));
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < NB; k++) begin
            check("a5_bit", 32'(uart_tx), 32'(exp_a5[k]));
            if (k != NB - 1) repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2 - 1) @(negedge clk);
        check("a5_busy_last", 32'(busy), 32'(1));
        @(negedge clk);
        check("a5_busy_done", 32'(busy), 32'(0));
        wait_idle(2 * FRAME_CYC);

        // Nine consecutive pushes fill the queue; a byte offered while full is dropped.
        base = rx_log.size();
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            @(negedge clk);
        end
        check("full_count", 32'(fifo_count), 32'(DEPTH));
        check("full_ready", 32'(in_ready), 32'(0));
        in_data = 8'hEE;
        n = 0;
        while (m_q.size() == DEPTH && n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (n >= 2 * FRAME_CYC) check("full_pop_timeout", 32'(fifo_count), 32'(DEPTH - 1));
        check("full_reject_count", 32'(fifo_count), 32'(DEPTH - 1));
        wait_idle(12 * FRAME_CYC);
        check("full_rx_n", 32'(rx_log.size() - base), 32'(9));
        ee_seen = 0;
        for (int i = 0; i < rx_log.size() - base; i++) begin
            if (i < 9) check("full_rx_order", 32'(rx_log[base+i]), 32'(i));
            if (rx_log[base+i] == 8'hEE) ee_seen++;
        end
        check("full_ee_absent", 32'(ee_seen), 32'(0));

        // Reset during data bit 3 of 0x3C with two bytes queued.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        @(negedge clk);
        in_data = 8'h11;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_count", 32'(fifo_count), 32'(2));
        n = 0;
        while (!(m_active && m_elapsed == 4 * CPB + CPB / 2) && n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FRAME_CYC) check("rst_wait_timeout", 32'(busy), 32'(0));
        base = rx_log.size();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_tx", 32'(uart_tx), 32'(1));
        check("rst_count", 32'(fifo_count), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        repeat (400) @(negedge clk);
        check("rst_no_frames", 32'(rx_log.size()), 32'(base));

`ifdef UART_TX_PARITY_EN
        // Parity bit values for 0x07 (three ones) and 0x03 (two ones).
        base = rx_log.size();
        in_valid = 1'b1;
        in_data  = 8'h07;
        @(negedge clk);
        in_data = 8'h03;
        @(negedge clk);
        in_valid = 1'b0;
        wait_idle(4 * FRAME_CYC);
        check("par_rx_n", 32'(rx_log.size() - base), 32'(2));
        if (rx_log.size() - base >= 2) begin
            check("par_07", 32'(rx_par_log[base]), 32'(1));
            check("par_03", 32'(rx_par_log[base+1]), 32'(0));
        end
`endif

        // Random traffic at three densities, one reset pulse in the middle round.
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 600; c++) begin
                in_valid = ($urandom_range(99) < dens[r]);
                in_data  = 8'($urandom);
                rst      = (r == 1 && c == 300);
                @(negedge clk);
            end
            in_valid = 1'b0;
            rst      = 1'b0;
            wait_idle((DEPTH + 2) * FRAME_CYC);
        end

        // Every completed frame must decode to the byte the model sent.
        check("rx_total", 32'(rx_log.size()), 32'(m_done.size()));
        for (int i = 0; i < rx_log.size() && i < m_done.size(); i++) begin
            check("rx_byte", 32'(rx_log[i]), 32'(m_done[i]));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
